// File: rtl/lbm_pkg.sv
// rtl/lbm_pkg.sv - shared D2Q9 lattice constants and distribution types
package lbm_pkg;

  localparam int DW = 16;

  localparam int F0 = 0;
  localparam int F1 = 1;
  localparam int F2 = 2;
  localparam int F3 = 3;
  localparam int F4 = 4;
  localparam int F5 = 5;
  localparam int F6 = 6;
  localparam int F7 = 7;
  localparam int F8 = 8;

  // Lattice velocities, +y points down the raster
  localparam logic signed [1:0] CX [9] = '{2'sb00, 2'sb01, 2'sb11, 2'sb00, 2'sb00,
                                           2'sb11, 2'sb01, 2'sb01, 2'sb11};
  localparam logic signed [1:0] CY [9] = '{2'sb00, 2'sb00, 2'sb00, 2'sb11, 2'sb01,
                                           2'sb11, 2'sb01, 2'sb11, 2'sb01};

  typedef logic signed [DW-1:0] f_word_t;
  typedef f_word_t [8:0] f_vec_t;

endpackage

// File: rtl/lbm_stream_unit_if.sv
// rtl/lbm_stream_unit_if.sv - cell stream and status bundle of the streaming stage
interface lbm_stream_unit_if #(
  parameter int W = 8,
  parameter int H = 8
);
  import lbm_pkg::*;

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic            in_valid;
  logic            in_ready;
  logic            in_init;
  f_vec_t          fi;
  logic            out_valid;
  logic            out_ready;
  f_vec_t          fo;
  logic [XW-1:0]   out_x;
  logic [YW-1:0]   out_y;
  logic            frame_done;
  logic [15:0]     frame_count;

  modport master (
    output in_valid, in_init, fi, out_ready,
    input  in_ready, out_valid, fo, out_x, out_y, frame_done, frame_count
  );

  modport slave (
    input  in_valid, in_init, fi, out_ready,
    output in_ready, out_valid, fo, out_x, out_y, frame_done, frame_count
  );

endinterface

// File: rtl/lbm_bank.sv
// rtl/lbm_bank.sv - one lattice bank: nine slot write ports, whole-cell read port
module lbm_bank
  import lbm_pkg::*;
#(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic                            clk,
  input  logic                            we_i,
  input  logic [8:0][$clog2(W*H)-1:0]     waddr_i,
  input  f_vec_t                          wdata_i,
  input  logic [$clog2(W*H)-1:0]          raddr_i,
  output f_vec_t                          rdata_o
);

  // Each slot index lives in its own array so all nine scattered writes land together
  for (genvar s = 0; s < 9; s++) begin : g_slot
    logic [DW-1:0] mem_q [W*H];

    // slot write, contents deliberately left unreset
    always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i[s]] <= wdata_i[s];
    end

    assign rdata_o[s] = mem_q[raddr_i];
  end

endmodule

// File: rtl/lbm_stream_unit.sv
// rtl/lbm_stream_unit.sv - ping-pong banked D2Q9 streaming stage with periodic wrap
module lbm_stream_unit
  import lbm_pkg::*;
#(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic               clk,
  input  logic               reset,
  lbm_stream_unit_if.slave   bus
);

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int AW = XW + YW;

  logic           wsel_q, wsel_d, rsel_q, rsel_d;
  logic [1:0]     full_q, full_d;
  logic [XW-1:0]  wx_q, wx_d, rx_q, rx_d;
  logic [YW-1:0]  wy_q, wy_d, ry_q, ry_d;
  logic [15:0]    frame_count_q, frame_count_d;
  logic           frame_done_q, frame_done_d;

  logic           wr_fire, rd_fire, wlast, rlast;
  logic [1:0]     bank_we;
  logic [8:0][AW-1:0] waddr;
  logic [AW-1:0]  raddr;
  f_vec_t         rdata [2];

  assign wr_fire = bus.in_valid && bus.in_ready;
  assign rd_fire = bus.out_valid && bus.out_ready;
  assign wlast   = (wx_q == XW'(W-1)) && (wy_q == YW'(H-1));
  assign rlast   = (rx_q == XW'(W-1)) && (ry_q == YW'(H-1));
  assign bank_we = {wr_fire && wsel_q, wr_fire && !wsel_q};
  assign raddr   = {ry_q, rx_q};

  // scatter targets: neighbour along each velocity, wrap comes from counter overflow
  always_comb begin
    waddr = '0;
    for (int i = F0; i <= F8; i++) begin
      if (bus.in_init) waddr[i] = {wy_q, wx_q};
      else             waddr[i] = {wy_q + YW'(CY[i]), wx_q + XW'(CX[i])};
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    lbm_bank #(.W(W), .H(H)) u_bank (
      .clk     (clk),
      .we_i    (bank_we[b]),
      .waddr_i (waddr),
      .wdata_i (bus.fi),
      .raddr_i (raddr),
      .rdata_o (rdata[b])
    );
  end

  // pointer advance and bank hand-over; fill and release may coincide on opposite banks
  always_comb begin
    wsel_d        = wsel_q;
    rsel_d        = rsel_q;
    full_d        = full_q;
    wx_d          = wx_q;
    wy_d          = wy_q;
    rx_d          = rx_q;
    ry_d          = ry_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    if (wr_fire) begin
      wx_d = wx_q + 1'b1;
      if (wx_q == XW'(W-1)) wy_d = wy_q + 1'b1;
      if (wlast) begin
        full_d[wsel_q] = 1'b1;
        wsel_d         = !wsel_q;
        frame_done_d   = 1'b1;
        frame_count_d  = frame_count_q + 16'd1;
      end
    end
    if (rd_fire) begin
      rx_d = rx_q + 1'b1;
      if (rx_q == XW'(W-1)) ry_d = ry_q + 1'b1;
      if (rlast) begin
        full_d[rsel_q] = 1'b0;
        rsel_d         = !rsel_q;
      end
    end
  end

  // control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wsel_q        <= 1'b0;
      rsel_q        <= 1'b0;
      full_q        <= 2'b00;
      wx_q          <= '0;
      wy_q          <= '0;
      rx_q          <= '0;
      ry_q          <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      wsel_q        <= wsel_d;
      rsel_q        <= rsel_d;
      full_q        <= full_d;
      wx_q          <= wx_d;
      wy_q          <= wy_d;
      rx_q          <= rx_d;
      ry_q          <= ry_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.in_ready    = !full_q[wsel_q];
  assign bus.out_valid   = full_q[rsel_q];
  assign bus.fo          = rsel_q ? rdata[1] : rdata[0];
  assign bus.out_x       = rx_q;
  assign bus.out_y       = ry_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_count = frame_count_q;

endmodule
